// File: rtl/stoch_arith_core.sv
// ---------------------------------------------------------------------------
// stoch_arith_core
//
// Stochastic-computing arithmetic unit. Two unsigned operands are turned into
// Bernoulli bit-streams by comparing them against free-running LFSRs. The
// streams are combined with an AND (multiply, a*b/2**WIDTH) or a random MUX
// (scaled add, (a+b)/2). The ones in the combined stream are counted over
// 2**LEN_LOG2 cycles and scaled back to a WIDTH-bit binary result.
//
// Ports
//   clk     in   1       rising-edge clock
//   rst_n   in   1       synchronous, active-low reset
//   start   in   1       operation request, accepted in IDLE
//   mode    in   1       0 = multiply, 1 = scaled add (latched on start)
//   a       in   WIDTH   operand A (latched on start)
//   b       in   WIDTH   operand B (latched on start)
//   busy    out  1       high while RUN or DONE
//   done    out  1       one-cycle pulse when result updates
//   result  out  WIDTH   last completed result, held until the next done
//
// Optional feature macro: STOCH_RESTART_EN
//   Defined   : start while in RUN aborts the current operation and restarts
//               with freshly latched operands (no done for the aborted run).
//   Undefined : start is ignored in RUN and DONE.
// ---------------------------------------------------------------------------
module stoch_arith_core #(
    parameter int               WIDTH    = 8,
    parameter int               LEN_LOG2 = 8,
    parameter logic [WIDTH-1:0] SEED_A   = WIDTH'(8'h01),
    parameter logic [WIDTH-1:0] SEED_B   = WIDTH'(8'h5A),
    parameter logic [WIDTH-1:0] SEED_S   = WIDTH'(8'hC3)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             mode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    // Elaboration-time parameter sanity.
    if (WIDTH < 4 || WIDTH > 16) begin : g_bad_width
        $error("stoch_arith_core: WIDTH must be in 4..16");
    end
    if (LEN_LOG2 < WIDTH) begin : g_bad_len
        $error("stoch_arith_core: LEN_LOG2 must be >= WIDTH");
    end
    if (SEED_A == '0 || SEED_B == '0 || SEED_S == '0) begin : g_zero_seed
        $error("stoch_arith_core: LFSR seeds must be non-zero");
    end
    if (SEED_A == SEED_B || SEED_A == SEED_S || SEED_B == SEED_S) begin : g_same_seed
        $error("stoch_arith_core: LFSR seeds must be distinct");
    end

    // Maximal-length feedback taps; bit n-1 set for polynomial term x^n.
    function automatic logic [15:0] tap_mask(input int w);
        case (w)
            4:       tap_mask = 16'h000C;  // x^4+x^3+1
            5:       tap_mask = 16'h0014;  // x^5+x^3+1
            6:       tap_mask = 16'h0030;  // x^6+x^5+1
            7:       tap_mask = 16'h0060;  // x^7+x^6+1
            8:       tap_mask = 16'h00B8;  // x^8+x^6+x^5+x^4+1
            9:       tap_mask = 16'h0110;  // x^9+x^5+1
            10:      tap_mask = 16'h0240;  // x^10+x^7+1
            11:      tap_mask = 16'h0500;  // x^11+x^9+1
            12:      tap_mask = 16'h0829;  // x^12+x^6+x^4+x+1
            13:      tap_mask = 16'h100D;  // x^13+x^4+x^3+x+1
            14:      tap_mask = 16'h2015;  // x^14+x^5+x^3+x+1
            15:      tap_mask = 16'h6000;  // x^15+x^14+1
            16:      tap_mask = 16'hD008;  // x^16+x^15+x^13+x^4+1
            default: tap_mask = 16'h0000;
        endcase
    endfunction

    localparam logic [15:0]         TAP16   = tap_mask(WIDTH);
    localparam logic [WIDTH-1:0]    TAPS    = TAP16[WIDTH-1:0];
    localparam logic [LEN_LOG2:0]   RES_MAX = {{(LEN_LOG2+1-WIDTH){1'b0}}, {WIDTH{1'b1}}};

    // Fibonacci step: shift left, feedback is the XOR of the tapped bits.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] s);
        lfsr_step = {s[WIDTH-2:0], ^(s & TAPS)};
    endfunction

    // Scale the ones count back to WIDTH bits; an all-ones stream
    // (count = 2**LEN_LOG2) would read as 2**WIDTH, so clamp it.
    function automatic logic [WIDTH-1:0] sat_result(input logic [LEN_LOG2:0] c);
        logic [LEN_LOG2:0] sh;
        sh = c >> (LEN_LOG2 - WIDTH);
        if (sh > RES_MAX) begin
            sat_result = '1;
        end else begin
            sat_result = sh[WIDTH-1:0];
        end
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              state_q,  state_d;
    logic [WIDTH-1:0]    a_q,      a_d;
    logic [WIDTH-1:0]    b_q,      b_d;
    logic                mode_q,   mode_d;
    logic [WIDTH-1:0]    lfsr_a_q, lfsr_a_d;
    logic [WIDTH-1:0]    lfsr_b_q, lfsr_b_d;
    logic [WIDTH-1:0]    lfsr_s_q, lfsr_s_d;
    logic [LEN_LOG2-1:0] cyc_q,    cyc_d;
    logic [LEN_LOG2:0]   count_q,  count_d;
    logic [WIDTH-1:0]    result_q, result_d;
    logic                done_q,   done_d;
    logic                busy_q,   busy_d;

    logic sa, sb, sel, out_bit, load_op;

    always_comb begin
        // Stream generation from the current LFSR states.
        sa      = (a_q > lfsr_a_q);
        sb      = (b_q > lfsr_b_q);
        sel     = lfsr_s_q[0];
        out_bit = mode_q ? (sel ? sa : sb) : (sa & sb);

        load_op = (state_q == S_IDLE) && start;
`ifdef STOCH_RESTART_EN
        load_op = load_op || ((state_q == S_RUN) && start);
`endif

        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        mode_d   = mode_q;
        lfsr_a_d = lfsr_a_q;
        lfsr_b_d = lfsr_b_q;
        lfsr_s_d = lfsr_s_q;
        cyc_d    = cyc_q;
        count_d  = count_q;
        result_d = result_q;
        done_d   = 1'b0;

        if (load_op) begin
            // Fresh (or restarted) operation: reseeding makes results repeatable.
            state_d  = S_RUN;
            a_d      = a;
            b_d      = b;
            mode_d   = mode;
            lfsr_a_d = SEED_A;
            lfsr_b_d = SEED_B;
            lfsr_s_d = SEED_S;
            cyc_d    = '0;
            count_d  = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    count_d  = count_q + (LEN_LOG2+1)'(out_bit);
                    cyc_d    = cyc_q + LEN_LOG2'(1);
                    lfsr_a_d = lfsr_step(lfsr_a_q);
                    lfsr_b_d = lfsr_step(lfsr_b_q);
                    lfsr_s_d = lfsr_step(lfsr_s_q);
                    // Last stream bit: cycle counter is about to wrap.
                    if (cyc_q == '1) begin
                        state_d  = S_DONE;
                        result_d = sat_result(count_d);
                        done_d   = 1'b1;
                    end
                end
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end

        busy_d = (state_d == S_RUN) || (state_d == S_DONE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            mode_q   <= 1'b0;
            lfsr_a_q <= SEED_A;
            lfsr_b_q <= SEED_B;
            lfsr_s_q <= SEED_S;
            cyc_q    <= '0;
            count_q  <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            mode_q   <= mode_d;
            lfsr_a_q <= lfsr_a_d;
            lfsr_b_q <= lfsr_b_d;
            lfsr_s_q <= lfsr_s_d;
            cyc_q    <= cyc_d;
            count_q  <= count_d;
            result_q <= result_d;
            done_q   <= done_d;
            busy_q   <= busy_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

endmodule

// File: tb/tb_stoch_arith_core.sv
// ---------------------------------------------------------------------------
// tb_stoch_arith_core
//
// Self-checking bench for stoch_arith_core (default parameters: WIDTH=8,
// LEN_LOG2=8). A table of operand records is applied in a loop; each
// expected result comes from an independent LFSR stream model and is queued
// when the start is driven, then popped when done is seen. Hand-written
// sequences cover reset, ignored/restarting starts and reset mid-RUN.
// Latency is counted in rising edges, the accepting edge being edge 1.
// ---------------------------------------------------------------------------
module tb_stoch_arith_core;

    localparam int LAT    = 257;
    localparam int BOUND  = LAT + 40;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start;
    logic       mode;
    logic [7:0] a_i;
    logic [7:0] b_i;
    logic       busy;
    logic       done;
    logic [7:0] result;

    int n_checks = 0;
    int n_pass   = 0;
    int done_cnt = 0;
    logic [7:0] exp_q[$];

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       m;
        int         lo;
        int         hi;
        string      name;
    } vec_t;

    vec_t vecs[7];

    stoch_arith_core dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .mode   (mode),
        .a      (a_i),
        .b      (b_i),
        .busy   (busy),
        .done   (done),
        .result (result)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (done) done_cnt++;
    end

    // Reference: x^8+x^6+x^5+x^4+1, shift left, seeds 01/5A/C3.
    function automatic logic [7:0] lfsr8(input logic [7:0] s);
        return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
    endfunction

    function automatic logic [7:0] model(input logic [7:0] a, input logic [7:0] b,
                                         input logic m);
        logic [7:0] la, lb, ls;
        int cnt;
        logic sa, sb, bt;
        la = 8'h01; lb = 8'h5A; ls = 8'hC3; cnt = 0;
        for (int i = 0; i < 256; i++) begin
            sa = (a > la);
            sb = (b > lb);
            bt = m ? (ls[0] ? sa : sb) : (sa & sb);
            cnt += int'(bt);
            la = lfsr8(la); lb = lfsr8(lb); ls = lfsr8(ls);
        end
        if (cnt > 255) cnt = 255;
        return 8'(cnt);
    endfunction

    task automatic check_eq(input string nm, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    endtask

    task automatic check_rng(input string nm, input int act, input int lo, input int hi);
        n_checks++;
        if (act >= lo && act <= hi) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d..%0d", nm, act, lo, hi);
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Drive one operation, scramble the inputs during RUN, wait for done.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic m,
                          input int lo, input int hi, input string nm,
                          output logic [7:0] res);
        int n;
        int d0;
        logic [7:0] held;
        bit stable;
        exp_q.push_back(model(a, b, m));
        d0 = done_cnt;
        a_i = a; b_i = b; mode = m; start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        a_i = ~a; b_i = ~b; mode = ~m;
        check_eq({nm, "_busy"}, int'(busy), 1);
        held = result;
        stable = 1'b1;
        while (!done && n < BOUND) begin
            tick;
            n++;
            if (!done && result !== held) stable = 1'b0;
        end
        check_eq({nm, "_latency"}, n, LAT);
        res = result;
        check_eq({nm, "_result"}, int'(result), int'(exp_q.pop_front()));
        check_rng({nm, "_range"}, int'(result), lo, hi);
        check_eq({nm, "_hold"}, int'(stable), 1);
        tick;
        check_eq({nm, "_idle"}, int'({busy, done}), 0);
        check_eq({nm, "_ndone"}, done_cnt - d0, 1);
    endtask

    initial begin
        logic [7:0] r1, r2, rx, exp_r;
        int n, d0;

        vecs[0] = '{8'd0,   8'd200, 1'b0, 0,   0,   "zero_a"};
        vecs[1] = '{8'd128, 8'd128, 1'b0, 56,  72,  "mul_half"};
        vecs[2] = '{8'd255, 8'd255, 1'b1, 254, 255, "add_full"};
        vecs[3] = '{8'd0,   8'd0,   1'b1, 0,   0,   "add_zero"};
        vecs[4] = '{8'd255, 8'd255, 1'b0, 250, 255, "mul_full"};
        vecs[5] = '{8'd200, 8'd100, 1'b0, 50,  110, "mul_mix"};
        vecs[6] = '{8'd16,  8'd240, 1'b1, 100, 156, "add_mix"};

        rst_n = 1'b0; start = 1'b0; mode = 1'b0; a_i = '0; b_i = '0;
        tick;
        tick;
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_result", int'(result), 0);
        rst_n = 1'b1;
        tick;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].m, vecs[i].lo, vecs[i].hi, vecs[i].name, rx);
        end

        run_op(8'd100, 8'd50, 1'b1, 55, 95, "rep1", r1);
        run_op(8'd100, 8'd50, 1'b1, 55, 95, "rep2", r2);
        check_eq("rep_equal", int'(r2), int'(r1));

`ifdef STOCH_RESTART_EN
        // Restart at RUN cycle 50; only the second operation completes.
        d0 = done_cnt;
        a_i = 8'd10; b_i = 8'd10; mode = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (n < 50) begin
            tick;
            n++;
        end
        exp_r = model(8'd255, 8'd255, 1'b0);
        a_i = 8'd255; b_i = 8'd255; mode = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (!done && n < BOUND) begin
            tick;
            n++;
        end
        check_eq("rst_en_latency", n, LAT);
        check_eq("rst_en_result", int'(result), int'(exp_r));
        check_rng("rst_en_range", int'(result), 252, 255);
        repeat (20) tick;
        check_eq("rst_en_ndone", done_cnt - d0, 1);
`else
        // Starts during RUN and DONE are ignored.
        d0 = done_cnt;
        exp_r = model(8'd100, 8'd50, 1'b1);
        a_i = 8'd100; b_i = 8'd50; mode = 1'b1; start = 1'b1;
        tick;
        start = 1'b0;
        n = 1;
        while (!done && n < BOUND) begin
            if (n == 50) begin
                a_i = 8'd255; b_i = 8'd255; mode = 1'b0; start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick;
            n++;
        end
        check_eq("ign_latency", n, LAT);
        check_eq("ign_result", int'(result), int'(exp_r));
        rx = result;
        start = 1'b1;
        tick;
        start = 1'b0;
        check_eq("ign_done_busy", int'(busy), 0);
        repeat (300) tick;
        check_eq("ign_ndone", done_cnt - d0, 1);
        check_eq("ign_result_held", int'(result), int'(rx));
        check_eq("ign_still_idle", int'(busy), 0);
`endif

        // Reset at RUN cycle 100 discards the operation and clears result.
        a_i = 8'd200; b_i = 8'd100; mode = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        repeat (99) tick;
        rst_n = 1'b0;
        tick;
        check_eq("midrst_busy", int'(busy), 0);
        check_eq("midrst_done", int'(done), 0);
        check_eq("midrst_result", int'(result), 0);
        rst_n = 1'b1;
        tick;
        run_op(8'd37, 8'd201, 1'b0, 15, 45, "post_rst", rx);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
